// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared encodings and widths for the DRAMCON user-port arbiter
package dram_pkg;

    localparam int DRAM_ADDR_W = 32;
    localparam int DRAM_DATA_W = 128;

    // Arbiter FSM encodings
    typedef enum logic [1:0] {
        ARB_IDLE_S  = 2'd0,
        ARB_ISSUE_S = 2'd1,
        ARB_WAIT_S  = 2'd2
    } arb_state_e;

    // Latched operation of the current owner; reset value is a read
    localparam logic DRAM_CMD_READ  = 1'b0;
    localparam logic DRAM_CMD_WRITE = 1'b1;

    // Index width for an n-entry requester vector, never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// rtl/dram_arbiter_if.sv - DRAMCON user-port bundle between arbiter and controller
interface dram_arbiter_if
    import dram_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) ();

    logic [ADDR_W-1:0] D_ADR;
    logic [DATA_W-1:0] D_DIN;
    logic              D_WE;
    logic              D_RE;
    logic              D_BUSY;
    logic [DATA_W-1:0] D_DOUT;
    logic              D_DOUTVALID;

    // Arbiter side drives the command, controller side answers
    modport master (
        output D_ADR, D_DIN, D_WE, D_RE,
        input  D_BUSY, D_DOUT, D_DOUTVALID
    );

    modport slave (
        input  D_ADR, D_DIN, D_WE, D_RE,
        output D_BUSY, D_DOUT, D_DOUTVALID
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick
    import dram_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // First requester at or after ptr_i, wrapping modulo NREQ
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing one DRAMCON user port among NREQ requesters
module dram_arbiter
    import dram_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int DATA_W = DRAM_DATA_W
) (
    input  logic                   CLK,
    input  logic                   RST_X,
    input  logic [NREQ-1:0]        REQ_WE,
    input  logic [NREQ-1:0]        REQ_RE,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADR,
    input  logic [NREQ*DATA_W-1:0] REQ_DIN,
    output logic [NREQ-1:0]        REQ_GNT,
    output logic [NREQ-1:0]        REQ_DONE,
    output logic [DATA_W-1:0]      REQ_DOUT,
    output logic                   ARB_IDLE,
    dram_arbiter_if.master         dram
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              op_q, op_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              err_read_lost_q, err_read_lost_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (REQ_WE | REQ_RE),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // State and latched transaction registers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q         <= ARB_IDLE_S;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            adr_q           <= '0;
            din_q           <= '0;
            op_q            <= DRAM_CMD_READ;
            gnt_q           <= '0;
            done_q          <= '0;
            dout_q          <= '0;
            err_read_lost_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            adr_q           <= adr_d;
            din_q           <= din_d;
            op_q            <= op_d;
            gnt_q           <= gnt_d;
            done_q          <= done_d;
            dout_q          <= dout_d;
            err_read_lost_q <= err_read_lost_d;
        end
    end

    // Next state: grant in IDLE, wait for busy to rise in ISSUE, fall in WAIT
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        adr_d           = adr_q;
        din_d           = din_q;
        op_d            = op_q;
        gnt_d           = '0;
        done_d          = '0;
        dout_d          = dout_q;
        err_read_lost_d = err_read_lost_q;
        case (state_q)
            ARB_IDLE_S: begin
                // Busy during calibration blocks all grants
                if (!dram.D_BUSY && pick_valid) begin
                    owner_d  = pick_idx;
                    adr_d    = REQ_ADR[int'(pick_idx)*ADDR_W +: ADDR_W];
                    din_d    = REQ_DIN[int'(pick_idx)*DATA_W +: DATA_W];
                    op_d     = REQ_WE[pick_idx] ? DRAM_CMD_WRITE : DRAM_CMD_READ;
                    gnt_d    = pick_gnt;
                    rr_ptr_d = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
                    state_d  = ARB_ISSUE_S;
                end
            end
            ARB_ISSUE_S: begin
                if (dram.D_BUSY) begin
                    state_d = ARB_WAIT_S;
                end
            end
            ARB_WAIT_S: begin
                if (!dram.D_BUSY) begin
                    done_d[owner_q] = 1'b1;
                    if (op_q == DRAM_CMD_READ) begin
                        dout_d = dram.D_DOUT;
                        // Completion is still reported so the requester never stalls
                        if (!dram.D_DOUTVALID) begin
                            err_read_lost_d = 1'b1;
                        end
                    end
                    state_d = ARB_IDLE_S;
                end
            end
            default: state_d = ARB_IDLE_S;
        endcase
    end

    assign dram.D_WE  = (state_q == ARB_ISSUE_S) && (op_q == DRAM_CMD_WRITE);
    assign dram.D_RE  = (state_q == ARB_ISSUE_S) && (op_q == DRAM_CMD_READ);
    assign dram.D_ADR = adr_q;
    assign dram.D_DIN = din_q;
    assign REQ_GNT    = gnt_q;
    assign REQ_DONE   = done_q;
    assign REQ_DOUT   = dout_q;
    assign ARB_IDLE   = (state_q == ARB_IDLE_S);

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_X) $onehot0(REQ_GNT));
    a_done_onehot: assert property (@(posedge CLK) disable iff (!RST_X) $onehot0(REQ_DONE));
    a_we_re_excl: assert property (@(posedge CLK) disable iff (!RST_X) !(dram.D_WE && dram.D_RE));
    a_cmd_in_issue: assert property (@(posedge CLK) disable iff (!RST_X)
        (dram.D_WE || dram.D_RE) |-> (state_q == ARB_ISSUE_S));
    a_read_not_lost: assert property (@(posedge CLK) disable iff (!RST_X) !err_read_lost_q);
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter with a DRAMCON model
module tb_dram_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 128;

    logic               CLK;
    logic               RST_X;
    logic [NREQ-1:0]    REQ_WE;
    logic [NREQ-1:0]    REQ_RE;
    logic [NREQ*AW-1:0] REQ_ADR;
    logic [NREQ*DW-1:0] REQ_DIN;
    logic [NREQ-1:0]    REQ_GNT;
    logic [NREQ-1:0]    REQ_DONE;
    logic [DW-1:0]      REQ_DOUT;
    logic               ARB_IDLE;

    dram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

    dram_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .REQ_WE   (REQ_WE),
        .REQ_RE   (REQ_RE),
        .REQ_ADR  (REQ_ADR),
        .REQ_DIN  (REQ_DIN),
        .REQ_GNT  (REQ_GNT),
        .REQ_DONE (REQ_DONE),
        .REQ_DOUT (REQ_DOUT),
        .ARB_IDLE (ARB_IDLE),
        .dram     (dif)
    );

    localparam logic [DW-1:0] RD_DATA = {4{32'hDEADBEEF}};
    localparam logic [DW-1:0] WR_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        cal_busy = 1'b1;
    int          mdl_cnt  = 0;
    logic        last_we  = 1'b0;
    logic        last_re  = 1'b0;
    logic [AW-1:0] last_adr = '0;
    logic [DW-1:0] last_din = '0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // DRAMCON model: samples on negedge, busy for three negedges per command
    initial begin
        dif.D_BUSY      = 1'b1;
        dif.D_DOUT      = '0;
        dif.D_DOUTVALID = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_X) begin
                mdl_cnt         = 0;
                dif.D_BUSY      = cal_busy;
                dif.D_DOUTVALID = 1'b0;
            end else if (cal_busy) begin
                dif.D_BUSY = 1'b1;
            end else if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) begin
                    dif.D_BUSY      = 1'b0;
                    dif.D_DOUTVALID = 1'b1;
                    dif.D_DOUT      = RD_DATA;
                end
            end else if (dif.D_WE || dif.D_RE) begin
                dif.D_BUSY      = 1'b1;
                dif.D_DOUTVALID = 1'b0;
                mdl_cnt         = 3;
                last_we         = dif.D_WE;
                last_re         = dif.D_RE;
                last_adr        = dif.D_ADR;
                last_din        = dif.D_DIN;
            end else begin
                dif.D_BUSY = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge with the arbiter idle and DRAMCON not busy
    task automatic do_txn(input int idx, input bit we, input bit re, input logic [AW-1:0] adr,
                          input logic [DW-1:0] din, input logic [DW-1:0] exp_dout);
        REQ_WE[idx] = we;
        REQ_RE[idx] = re;
        REQ_ADR[idx*AW +: AW] = adr;
        REQ_DIN[idx*DW +: DW] = din;
        @(negedge CLK);
        chk("txn_gnt", REQ_GNT, 128'(1 << idx));
        chk("txn_d_we", dif.D_WE, we);
        chk("txn_d_re", dif.D_RE, re && !we);
        chk("txn_d_adr", dif.D_ADR, adr);
        if (we) chk("txn_d_din", dif.D_DIN, din);
        chk("txn_busy_not_idle", ARB_IDLE, 1'b0);
        REQ_WE[idx] = 1'b0;
        REQ_RE[idx] = 1'b0;
        @(negedge CLK);
        chk("txn_cmd_dropped", {dif.D_WE, dif.D_RE}, 2'b00);
        chk("txn_mdl_we", last_we, we);
        chk("txn_mdl_adr", last_adr, adr);
        repeat (2) @(negedge CLK);
        chk("txn_no_early_done", REQ_DONE, '0);
        chk("txn_adr_held", dif.D_ADR, adr);
        @(negedge CLK);
        chk("txn_done", REQ_DONE, 128'(1 << idx));
        chk("txn_dout", REQ_DOUT, exp_dout);
        chk("txn_idle", ARB_IDLE, 1'b1);
    endtask

    initial begin
        int   order[9];
        int   n_gnt;
        logic seen;

        RST_X   = 1'b0;
        REQ_WE  = '0;
        REQ_RE  = '0;
        REQ_ADR = '0;
        REQ_DIN = '0;
        repeat (3) @(negedge CLK);
        chk("rst_idle", ARB_IDLE, 1'b1);
        chk("rst_gnt", REQ_GNT, '0);
        chk("rst_done", REQ_DONE, '0);
        chk("rst_cmd", {dif.D_WE, dif.D_RE}, 2'b00);
        chk("rst_dout", REQ_DOUT, '0);
        #2 RST_X = 1'b1;

        // Calibration hold: requester 0 waits while busy stays high
        REQ_WE[0]       = 1'b1;
        REQ_ADR[0 +: AW] = 32'h0000_0040;
        REQ_DIN[0 +: DW] = WR_DATA;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            seen = seen | (|REQ_GNT);
        end
        chk("cal_no_gnt", seen, 1'b0);
        @(posedge CLK);
        #1 cal_busy = 1'b0;
        @(negedge CLK);
        chk("cal_gnt_early", REQ_GNT, '0);
        @(negedge CLK);
        chk("cal_gnt", REQ_GNT, 3'b001);
        REQ_WE[0] = 1'b0;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        chk("cal_done", REQ_DONE, 3'b001);

        // Single write, single read, then write-wins on requester 2
        do_txn(1, 1'b1, 1'b0, 32'h0000_0100, WR_DATA, '0);
        do_txn(0, 1'b0, 1'b1, 32'h0000_0100, '0, RD_DATA);
        do_txn(2, 1'b1, 1'b1, 32'h0000_0280, ~WR_DATA, RD_DATA);

        // Fairness: all three read continuously, pointer starts at 0
        for (int k = 0; k < 9; k++) order[k] = -1;
        n_gnt  = 0;
        REQ_RE = '1;
        for (int c = 0; c < 200 && n_gnt < 9; c++) begin
            @(negedge CLK);
            for (int j = 0; j < NREQ; j++) begin
                if (REQ_GNT[j]) begin
                    order[n_gnt] = j;
                    n_gnt++;
                end
            end
        end
        REQ_RE = '0;
        chk("fair_count", n_gnt, 9);
        for (int k = 0; k < 9; k++) chk("fair_order", order[k], k % 3);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            seen = |REQ_DONE;
        end
        chk("fair_last_done", seen, 1'b1);

        // Reset while requester 1 read is in WAIT
        REQ_RE[1]         = 1'b1;
        REQ_ADR[AW +: AW] = 32'h0000_0200;
        @(negedge CLK);
        chk("rstw_gnt", REQ_GNT, 3'b010);
        REQ_RE[1] = 1'b0;
        @(negedge CLK);
        #2 RST_X = 1'b0;
        #1;
        chk("rstw_idle", ARB_IDLE, 1'b1);
        chk("rstw_gnt0", REQ_GNT, '0);
        chk("rstw_done0", REQ_DONE, '0);
        chk("rstw_cmd", {dif.D_WE, dif.D_RE}, 2'b00);
        chk("rstw_adr", dif.D_ADR, '0);
        chk("rstw_dout", REQ_DOUT, '0);
        repeat (2) @(negedge CLK);
        #2 RST_X = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            seen = seen | (|REQ_DONE);
        end
        chk("rstw_no_done", seen, 1'b0);
        do_txn(1, 1'b1, 1'b0, 32'h0000_0300, WR_DATA, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
